raster_writeback_sequencer: RTL



---
 rtl/raster_writeback_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/raster_writeback_sequencer.sv
// raster_writeback_sequencer
// Merges the scanline streams of NCORES raster cores into one AXI-stream
// frame. Cores are drained strictly in ascending index. The first pixel of
// the frame is tagged with tuser (SOF) and the final pixel with tlast (EOF).
//
// Ports:
//   clk, nreset     clock, synchronous active-low reset
//   start           frame drain request (honoured in IDLE only)
//   core_valid      per-core pixel valid            [NCORES]
//   core_data       per-core pixel, core i at [i*DWIDTH +: DWIDTH]
//   core_last       per-core last-pixel-of-line flag [NCORES]
//   core_handshake  one-hot transfer acknowledge     [NCORES]
//   m_axis_*        merged output stream (tvalid/tdata/tlast/tuser/tready)
//   busy            high while draining a frame (ACTIVE and DONE)
//   frame_done      one-cycle pulse after the final transfer
//   len_error       sticky line-length mismatch flag
module raster_writeback_sequencer #(
  parameter int unsigned NCORES = 32,
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned X_LEN  = 400
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       start,
  input  logic [NCORES-1:0]          core_valid,
  input  logic [NCORES*DWIDTH-1:0]   core_data,
  input  logic [NCORES-1:0]          core_last,
  output logic [NCORES-1:0]          core_handshake,
  output logic                       m_axis_tvalid,
  output logic [DWIDTH-1:0]          m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  input  logic                       m_axis_tready,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       len_error
);

  localparam int unsigned SEL_W = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int unsigned CNT_W = (X_LEN > 1) ? $clog2(X_LEN) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NCORES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(X_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] pix_cnt;

  logic active;
  logic cnt_end;
  logic line_end;
  logic xfer;

  // Combinational core-to-stream path; gated by reset so an aborting frame
  // issues no handshake in the reset cycle.
  always_comb begin
    active         = (state == ACTIVE) && nreset;
    cnt_end        = (pix_cnt == CNT_LAST);
    line_end       = 1'b0;
    xfer           = 1'b0;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tuser   = 1'b0;
    m_axis_tlast   = 1'b0;
    core_handshake = '0;
    if (active) begin
      line_end       = core_last[sel] | cnt_end;
      m_axis_tvalid  = core_valid[sel];
      m_axis_tdata   = core_data[sel*DWIDTH +: DWIDTH];
      xfer           = m_axis_tvalid & m_axis_tready;
      core_handshake = NCORES'(xfer) << sel;
      m_axis_tuser   = m_axis_tvalid & (sel == '0) & (pix_cnt == '0);
      m_axis_tlast   = m_axis_tvalid & (sel == SEL_LAST) & line_end;
    end
  end

  // Sequencer state, line/pixel counters and status flags.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= IDLE;
      sel        <= '0;
      pix_cnt    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      len_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ACTIVE;
            sel       <= '0;
            pix_cnt   <= '0;
            busy      <= 1'b1;
            len_error <= 1'b0;
          end
        end
        ACTIVE: begin
          if (xfer) begin
            if (line_end) begin
              // Early last closes the line short; missing last closes at X_LEN.
              if (core_last[sel] != cnt_end) begin
                len_error <= 1'b1;
              end
              pix_cnt <= '0;
              if (sel == SEL_LAST) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end else begin
                sel <= sel + SEL_W'(1);
              end
            end else begin
              pix_cnt <= pix_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
